step_pulse_receiver: RTL and testbench
======================================

// Module: step_pulse_receiver
// PURPOSE
//  Receive end of the step/dir interface driven by the 8-bit phase-accumulator pulse generator.
//  Synchronises Pls_In/Dir_In/Ref_In, keeps a signed up/down position count, and runs a
//  homing sequence that loads the count on the Ref falling edge.
//  Also measures the Clk period between step pulses so the controller can close the speed loop.
//  One instance per motor axis, alongside the pulse generator on the same Clk.
// PARAMETERS
//  CNT_W   20  width of position counter PlsCnt (two's complement, wraps)
//  REF_W   16  width of RefPos home-position preset
//  PER_W   16  width of period timer / PlsPeriod
// PORTS
//  Clk         in   1      system clock, all logic on rising edge
//  gRst_n      in   1      asynchronous active-low reset
//  Pls_In      in   1      step pulse, async to Clk; rising edge = one step
//  Dir_In      in   1      direction, async; 1 = count up, 0 = count down
//  Ref_In      in   1      home switch, async; falling edge = home event
//  RefEn       in   1      level; 1 arms homing (ARMED state)
//  RefClr      in   1      1-Clk pulse; clears RefDone, returns FSM to IDLE
//  PlsClr      in   1      1-Clk pulse; synchronous clear of PlsCnt
//  RefPos      in   REF_W  value loaded into PlsCnt at home event (zero-extended)
//  PlsCnt      out  CNT_W  current position count
//  RefDone     out  1      homing complete flag (sticky)
//  PlsPeriod   out  PER_W  Clk cycles between last two step edges
//  PeriodVld   out  1      1-Clk strobe when PlsPeriod updated
//  Stalled     out  1      1 while period timer saturated (no steps)
// BEHAVIOUR
//  - Reset (gRst_n=0): all sync regs 0, PlsCnt=0, RefDone=0, PlsPeriod=0, PeriodVld=0,
//    Stalled=0, period timer=0, FSM=IDLE. Async assert, release synchronised to Clk by use.
//  - Sync: each async input through 2 flops (s0->s1) plus history flop s2.
//    PlsEdge = s1 & ~s2 on Pls. RefFall = ~s1 & s2 on Ref.
//  - Latency: PlsCnt changes on the 3rd Clk edge after Pls_In is first sampled high.
//    Inputs need >= 2 Clk high and >= 2 Clk low; shorter pulses may be lost.
//  - Dir_In is sampled through the same sync depth; the value aligned with PlsEdge is used.
//  - PlsCnt priority per cycle: PlsClr > home load > PlsEdge count.
//    Up at all-ones wraps to 0; down at 0 wraps to all-ones. No saturation.
//  - FSM IDLE -> ARMED when RefEn=1 and RefDone=0.
//    ARMED -> IDLE if RefEn drops before a home event.
//    ARMED & RefFall -> HOMED: PlsCnt<=RefPos, RefDone<=1 same edge; a PlsEdge that cycle is dropped.
//    HOMED holds RefDone=1 and ignores Ref_In; RefClr -> IDLE, RefDone<=0.
//    RefClr in ARMED -> IDLE. RefClr and RefFall in same cycle: RefClr wins, no load.
//  - Period timer counts +1 per Clk and saturates at all-ones (sets Stalled=1).
//    On PlsEdge: PlsPeriod<=timer+1, timer<=0, PeriodVld=1 for one Clk, Stalled<=0.
//    If saturated: PlsPeriod<=all-ones.
//  - First PlsEdge after reset reports the time since reset (caller discards it).
//  - PlsClr does not affect the period timer, FSM or RefDone.
// TESTING
//  1 Reset mid-count: PlsCnt=0x00123, assert gRst_n=0 -> all outputs 0 immediately, FSM IDLE.
//  2 Dir=1, 5 pulses (4 Clk hi/4 lo) -> PlsCnt=5; Dir=0, 7 pulses -> PlsCnt=0xFFFFE.
//    Each update lands 3 Clk after the rise.
//  3 Wrap: PlsClr, Dir=0, 1 pulse -> 0xFFFFF; Dir=1, 1 pulse -> 0x00000.
//  4 Homing: RefEn=1, PlsCnt=0x00040, Ref 1->0 coincident with PlsEdge, RefPos=0x1234
//    -> PlsCnt=0x01234, RefDone=1. A second Ref fall gives no reload.
//    RefClr -> RefDone=0.
//  5 Period: pulses every 100 Clk -> PlsPeriod=100 with a PeriodVld strobe per pulse.
//    No pulses for 70000 Clk -> Stalled=1; next pulse -> PlsPeriod=0xFFFF, Stalled=0.
//  6 Glitch: 1-Clk-wide Pls_In high -> no required count; PlsClr with PlsEdge in same cycle
//    -> PlsCnt=0.

Source files
------------

// File: rtl/step_pulse_receiver.sv
// Step/dir receiver: synchronised up/down position count, Ref-edge homing, step-period timer.
// PlsCnt updates on the 3rd Clk edge after Pls_In is first sampled high; no backpressure, inputs are sampled every Clk.
module step_pulse_receiver #(
   parameter int CNT_W = 20,
   parameter int REF_W = 16,
   parameter int PER_W = 16
) (
   input  logic             Clk,
   input  logic             gRst_n,
   input  logic             Pls_In,
   input  logic             Dir_In,
   input  logic             Ref_In,
   input  logic             RefEn,
   input  logic             RefClr,
   input  logic             PlsClr,
   input  logic [REF_W-1:0] RefPos,
   output logic [CNT_W-1:0] PlsCnt,
   output logic             RefDone,
   output logic [PER_W-1:0] PlsPeriod,
   output logic             PeriodVld,
   output logic             Stalled
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HOMED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       pls_s_q, ref_s_q;
   logic [1:0]       dir_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PER_W-1:0] tmr_q, tmr_d;
   logic [PER_W-1:0] per_q, per_d;
   logic             vld_q, vld_d;
   logic             pls_edge, ref_fall, dir_up, home_load, tmr_sat;

   // Bit 0 is the first capture flop, bit 1 the settled value, bit 2 its history.
   always_ff @(posedge Clk or negedge gRst_n) begin
      if (!gRst_n) begin
         pls_s_q <= '0;
         ref_s_q <= '0;
         dir_s_q <= '0;
      end else begin
         pls_s_q <= {pls_s_q[1:0], Pls_In};
         ref_s_q <= {ref_s_q[1:0], Ref_In};
         dir_s_q <= {dir_s_q[0], Dir_In};
      end
   end

   assign pls_edge = pls_s_q[1] & ~pls_s_q[2];
   assign ref_fall = ~ref_s_q[1] & ref_s_q[2];
   assign dir_up   = dir_s_q[1];
   assign tmr_sat  = &tmr_q;

   always_comb begin
      state_d   = state_q;
      home_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (RefEn) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            // Clear or disarm beats a coincident home edge.
            if (RefClr || !RefEn) begin
               state_d = ST_IDLE;
            end else if (ref_fall) begin
               state_d   = ST_HOMED;
               home_load = 1'b1;
            end
         end
         ST_HOMED: begin
            if (RefClr) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (PlsClr) begin
         cnt_d = '0;
      end else if (home_load) begin
         cnt_d = CNT_W'(RefPos);
      end else if (pls_edge) begin
         cnt_d = dir_up ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
      end
   end

   always_comb begin
      tmr_d = tmr_sat ? tmr_q : tmr_q + PER_W'(1);
      per_d = per_q;
      vld_d = 1'b0;
      if (pls_edge) begin
         tmr_d = '0;
         per_d = tmr_sat ? '1 : tmr_q + PER_W'(1);
         vld_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge gRst_n) begin
      if (!gRst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tmr_q   <= '0;
         per_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         per_q   <= per_d;
         vld_q   <= vld_d;
      end
   end

   assign PlsCnt    = cnt_q;
   assign RefDone   = (state_q == ST_HOMED);
   assign PlsPeriod = per_q;
   assign PeriodVld = vld_q;
   assign Stalled   = tmr_sat;

endmodule

// File: tb/tb_step_pulse_receiver.sv
// Bench for step_pulse_receiver: randomized step trains against a transaction-level count/period model.
module tb_step_pulse_receiver;
   localparam int CNT_W = 20;
   localparam int REF_W = 16;
   localparam int PER_W = 16;

   logic             Clk;
   logic             gRst_n;
   logic             Pls_In, Dir_In, Ref_In, RefEn, RefClr, PlsClr;
   logic [REF_W-1:0] RefPos;
   logic [CNT_W-1:0] PlsCnt;
   logic             RefDone;
   logic [PER_W-1:0] PlsPeriod;
   logic             PeriodVld;
   logic             Stalled;

   step_pulse_receiver #(.CNT_W(CNT_W), .REF_W(REF_W), .PER_W(PER_W)) dut (
      .Clk(Clk), .gRst_n(gRst_n), .Pls_In(Pls_In), .Dir_In(Dir_In), .Ref_In(Ref_In),
      .RefEn(RefEn), .RefClr(RefClr), .PlsClr(PlsClr), .RefPos(RefPos),
      .PlsCnt(PlsCnt), .RefDone(RefDone), .PlsPeriod(PlsPeriod),
      .PeriodVld(PeriodVld), .Stalled(Stalled)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int          n_pass  = 0;
   int          n_total = 0;
   int unsigned cyc     = 0;
   int          vld_cnt = 0;
   logic [15:0] last_per = '0;
   logic [19:0] m_cnt = '0;
   int unsigned last_rise = 0;
   int unsigned prev_rise = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (PeriodVld === 1'b1) begin
         vld_cnt  = vld_cnt + 1;
         last_per = PlsPeriod;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Drives one step pulse starting at a falling Clk edge and logs its rise cycle.
   task automatic drive_pulse(input logic d, input int hi, input int lo);
      Dir_In    = d;
      Pls_In    = 1'b1;
      prev_rise = last_rise;
      last_rise = cyc;
      wait_n(hi);
      Pls_In = 1'b0;
      wait_n(lo);
   endtask

   function automatic logic [19:0] step(input logic [19:0] c, input logic d);
      return d ? c + 20'd1 : c - 20'd1;
   endfunction

   task automatic test_reset();
      gRst_n = 1'b0; Pls_In = 0; Dir_In = 0; Ref_In = 0; RefEn = 0; RefClr = 0; PlsClr = 0;
      RefPos = '0;
      wait_n(3);
      n_total++; if (PlsCnt !== 20'h0) $display("FAIL reset_cnt: got %h want 0", PlsCnt); else n_pass++;
      n_total++; if (RefDone !== 1'b0) $display("FAIL reset_refdone: got %b want 0", RefDone); else n_pass++;
      n_total++; if (PlsPeriod !== 16'h0) $display("FAIL reset_period: got %h want 0", PlsPeriod); else n_pass++;
      n_total++; if (PeriodVld !== 1'b0) $display("FAIL reset_vld: got %b want 0", PeriodVld); else n_pass++;
      n_total++; if (Stalled !== 1'b0) $display("FAIL reset_stalled: got %b want 0", Stalled); else n_pass++;
      gRst_n = 1'b1;
      m_cnt  = '0;
      wait_n(2);
   endtask

   // Five steps up then seven down, watching each update land on the 3rd edge.
   task automatic test_updown();
      logic [19:0] nxt;
      for (int i = 0; i < 12; i++) begin
         logic d;
         d   = (i < 5);
         nxt = step(m_cnt, d);
         Dir_In = d;
         Pls_In = 1'b1;
         wait_n(2);
         n_total++; if (PlsCnt !== m_cnt) $display("FAIL latency_early[%0d]: got %h want %h", i, PlsCnt, m_cnt); else n_pass++;
         wait_n(1);
         n_total++; if (PlsCnt !== nxt) $display("FAIL latency_3rd[%0d]: got %h want %h", i, PlsCnt, nxt); else n_pass++;
         wait_n(1);
         Pls_In = 1'b0;
         wait_n(4);
         m_cnt = nxt;
         if (i == 4) begin
            n_total++; if (PlsCnt !== 20'h5) $display("FAIL updown_up5: got %h want 00005", PlsCnt); else n_pass++;
         end
      end
      n_total++; if (PlsCnt !== 20'hFFFFE) $display("FAIL updown_final: got %h want FFFFE", PlsCnt); else n_pass++;
   endtask

   task automatic test_wrap();
      PlsClr = 1'b1;
      wait_n(1);
      PlsClr = 1'b0;
      n_total++; if (PlsCnt !== 20'h0) $display("FAIL wrap_clr: got %h want 0", PlsCnt); else n_pass++;
      drive_pulse(1'b0, 3, 3);
      n_total++; if (PlsCnt !== 20'hFFFFF) $display("FAIL wrap_down: got %h want FFFFF", PlsCnt); else n_pass++;
      drive_pulse(1'b1, 3, 3);
      n_total++; if (PlsCnt !== 20'h00000) $display("FAIL wrap_up: got %h want 00000", PlsCnt); else n_pass++;
      m_cnt = '0;
   endtask

   task automatic test_random_count();
      for (int i = 0; i < 24; i++) begin
         logic d;
         int hi, lo;
         d  = 1'($urandom_range(1, 0));
         hi = int'($urandom_range(5, 2));
         lo = int'($urandom_range(5, 2));
         drive_pulse(d, hi, lo);
         m_cnt = step(m_cnt, d);
         n_total++; if (PlsCnt !== m_cnt) $display("FAIL rand_count[%0d]: got %h want %h", i, PlsCnt, m_cnt); else n_pass++;
      end
   endtask

   task automatic test_homing();
      PlsClr = 1'b1; wait_n(1); PlsClr = 1'b0;
      for (int i = 0; i < 64; i++) drive_pulse(1'b1, 2, 2);
      n_total++; if (PlsCnt !== 20'h00040) $display("FAIL home_pre: got %h want 00040", PlsCnt); else n_pass++;
      Ref_In = 1'b1; RefPos = 16'h1234; RefEn = 1'b1;
      wait_n(4);
      // Ref falls on the same cycle a step rises: the load wins and the step is dropped.
      Ref_In = 1'b0;
      drive_pulse(1'b1, 2, 4);
      n_total++; if (PlsCnt !== 20'h01234) $display("FAIL home_load: got %h want 01234", PlsCnt); else n_pass++;
      n_total++; if (RefDone !== 1'b1) $display("FAIL home_done: got %b want 1", RefDone); else n_pass++;
      drive_pulse(1'b1, 2, 2);
      RefPos = 16'h0777;
      Ref_In = 1'b1; wait_n(3); Ref_In = 1'b0; wait_n(4);
      n_total++; if (PlsCnt !== 20'h01235) $display("FAIL home_noreload: got %h want 01235", PlsCnt); else n_pass++;
      n_total++; if (RefDone !== 1'b1) $display("FAIL home_sticky: got %b want 1", RefDone); else n_pass++;
      RefClr = 1'b1; wait_n(1); RefClr = 1'b0;
      n_total++; if (RefDone !== 1'b0) $display("FAIL home_refclr: got %b want 0", RefDone); else n_pass++;
      RefEn = 1'b0; wait_n(2);
      Ref_In = 1'b1; wait_n(3); Ref_In = 1'b0; wait_n(4);
      n_total++; if (PlsCnt !== 20'h01235) $display("FAIL home_disarm: got %h want 01235", PlsCnt); else n_pass++;
      Ref_In = 1'b1; RefEn = 1'b1; wait_n(4);
      Ref_In = 1'b0; wait_n(2);
      RefClr = 1'b1; wait_n(1); RefClr = 1'b0; wait_n(3);
      n_total++; if (PlsCnt !== 20'h01235) $display("FAIL home_clr_vs_fall_cnt: got %h want 01235", PlsCnt); else n_pass++;
      n_total++; if (RefDone !== 1'b0) $display("FAIL home_clr_vs_fall_done: got %b want 0", RefDone); else n_pass++;
      RefEn = 1'b0;
      wait_n(2);
      m_cnt = 20'h01235;
   endtask

   task automatic test_glitch_clr();
      Dir_In = 1'b1;
      Pls_In = 1'b1; wait_n(1); Pls_In = 1'b0; wait_n(6);
      Pls_In = 1'b1; wait_n(2);
      PlsClr = 1'b1; wait_n(1); PlsClr = 1'b0;
      n_total++; if (PlsCnt !== 20'h0) $display("FAIL clr_vs_edge: got %h want 0", PlsCnt); else n_pass++;
      wait_n(1); Pls_In = 1'b0; wait_n(3);
      n_total++; if (PlsCnt !== 20'h0) $display("FAIL clr_vs_edge_hold: got %h want 0", PlsCnt); else n_pass++;
      m_cnt = '0;
   endtask

   task automatic test_period_random();
      drive_pulse(1'b1, 3, 3);
      m_cnt = step(m_cnt, 1'b1);
      for (int i = 0; i < 16; i++) begin
         int ivl, hi, v0;
         int unsigned expv;
         logic d;
         ivl  = (i < 4) ? 100 : int'($urandom_range(300, 4));
         hi   = int'($urandom_range(ivl - 2, 2));
         d    = 1'($urandom_range(1, 0));
         v0   = vld_cnt;
         drive_pulse(d, hi, ivl - hi);
         m_cnt = step(m_cnt, d);
         expv  = last_rise - prev_rise;
         if (expv > 32'hFFFF) expv = 32'hFFFF;
         n_total++; if (vld_cnt !== v0 + 1) $display("FAIL period_strobes[%0d]: got %0d want %0d", i, vld_cnt - v0, 1); else n_pass++;
         n_total++; if (last_per !== expv[15:0]) $display("FAIL period_value[%0d]: got %0d want %0d", i, last_per, expv); else n_pass++;
         n_total++; if (PlsCnt !== m_cnt) $display("FAIL period_count[%0d]: got %h want %h", i, PlsCnt, m_cnt); else n_pass++;
      end
   endtask

   task automatic test_stall();
      int v0;
      drive_pulse(1'b1, 2, 2);
      m_cnt = step(m_cnt, 1'b1);
      v0 = vld_cnt;
      wait_n(65000 - 4);
      n_total++; if (Stalled !== 1'b0) $display("FAIL stall_early: got %b want 0", Stalled); else n_pass++;
      wait_n(5000);
      n_total++; if (Stalled !== 1'b1) $display("FAIL stall_set: got %b want 1", Stalled); else n_pass++;
      n_total++; if (vld_cnt !== v0) $display("FAIL stall_nostrobe: got %0d want 0", vld_cnt - v0); else n_pass++;
      drive_pulse(1'b1, 2, 2);
      m_cnt = step(m_cnt, 1'b1);
      n_total++; if (last_per !== 16'hFFFF) $display("FAIL stall_period: got %h want FFFF", last_per); else n_pass++;
      n_total++; if (Stalled !== 1'b0) $display("FAIL stall_clear: got %b want 0", Stalled); else n_pass++;
      n_total++; if (vld_cnt !== v0 + 1) $display("FAIL stall_strobe: got %0d want 1", vld_cnt - v0); else n_pass++;
      n_total++; if (PlsCnt !== m_cnt) $display("FAIL stall_count: got %h want %h", PlsCnt, m_cnt); else n_pass++;
   endtask

   // Home to 0x123, then pull reset mid-run and check outputs drop without a clock edge.
   task automatic test_reset_midcount();
      Ref_In = 1'b1; RefPos = 16'h0123; RefEn = 1'b1;
      wait_n(4);
      Ref_In = 1'b0;
      wait_n(4);
      n_total++; if (PlsCnt !== 20'h00123) $display("FAIL midrst_pre: got %h want 00123", PlsCnt); else n_pass++;
      gRst_n = 1'b0;
      #1;
      n_total++; if (PlsCnt !== 20'h0) $display("FAIL midrst_cnt: got %h want 0", PlsCnt); else n_pass++;
      n_total++; if (RefDone !== 1'b0) $display("FAIL midrst_done: got %b want 0", RefDone); else n_pass++;
      n_total++; if (PlsPeriod !== 16'h0) $display("FAIL midrst_period: got %h want 0", PlsPeriod); else n_pass++;
      n_total++; if (Stalled !== 1'b0) $display("FAIL midrst_stalled: got %b want 0", Stalled); else n_pass++;
      RefEn = 1'b0;
      wait_n(2);
      gRst_n = 1'b1;
      wait_n(3);
      n_total++; if (RefDone !== 1'b0) $display("FAIL midrst_idle: got %b want 0", RefDone); else n_pass++;
      n_total++; if (PlsCnt !== 20'h0) $display("FAIL midrst_after: got %h want 0", PlsCnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_updown();
      test_wrap();
      test_random_count();
      test_homing();
      test_glitch_clr();
      test_period_random();
      test_stall();
      test_reset_midcount();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
